chacha20_sched: RTL and testbench
=================================

CHACHA20_SCHED -- requirements
Module: chacha20_sched

Interface
REQ-001 Parameter: TMO, 255, WAIT-state cycles without cor_don before a block is aborted (1..65535).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_0/req_1  in  1  per-channel job request, level, sampled each cycle.
REQ-005 key_0/key_1  in  256  per-channel key, valid with req_x.
REQ-006 non_0/non_1  in  96  per-channel nonce, valid with req_x.
REQ-007 ini_0/ini_1  in  32  per-channel initial block counter, valid with req_x.
REQ-008 nbk_0/nbk_1  in  8  per-channel block count for the job.
REQ-009 gnt_0/gnt_1  out  1  one-cycle pulse, job accepted.
REQ-010 bsy_0/bsy_1  out  1  channel job in progress.
REQ-011 blk_0/blk_1  out  1  one-cycle pulse per completed keystream block.
REQ-012 fin_0/fin_1  out  1  one-cycle pulse, all blocks of job done.
REQ-013 err_0/err_1  out  1  one-cycle pulse, job aborted on timeout.
REQ-014 cor_key  out  256, cor_non  out  96, cor_cnt  out  32  operands driven to the shared ChaCha20 core.
REQ-015 cor_str  out  1  one-cycle core start; cor_sel  out  1  channel in service.
REQ-016 cor_don  in  1  one-cycle core completion pulse.

Function
REQ-017 Channel idle (bsy_x=0) and req_x=1 -> latch key/non/ini/nbk, gnt_x=1 next cycle, bsy_x=1 same cycle as gnt_x.
REQ-018 req_x while bsy_x=1 ignored; no gnt, no latch.
REQ-019 Both channels accept independently in the same cycle.
REQ-020 Accepted job with nbk=0 -> fin_x one cycle after gnt_x, bsy_x cleared with fin_x, core untouched.
REQ-021 Scheduler FSM states IDLE, ISSUE, WAIT.
REQ-022 IDLE: if any channel has remaining blocks, select per round-robin pointer (pointer channel first, else the other), cor_sel set, -> ISSUE next cycle; else stay.
REQ-023 ISSUE: cor_str=1 for exactly one cycle, cor_key/non/cnt = selected channel's latched key, nonce, current counter; pointer := other channel; -> WAIT.
REQ-024 cor_key/non/cnt/cor_sel held stable from ISSUE until return to IDLE.
REQ-025 WAIT + cor_don: blk_x pulse next cycle, counter +1 modulo 2^32 (0xFFFFFFFF -> 0x00000000), remaining -1, -> IDLE.
REQ-026 Remaining reaching 0 on that cor_don: fin_x pulses same cycle as final blk_x, bsy_x cleared same cycle.
REQ-027 WAIT timer counts cycles from entry; reaching TMO without cor_don: err_x pulse, channel job discarded (bsy_x cleared, no fin_x), -> IDLE.
REQ-028 cor_don and timeout in same cycle: cor_don wins.
REQ-029 cor_don outside WAIT ignored.
REQ-030 Block issue granularity: channels interleave block-by-block; no channel receives two consecutive blocks while the other has remaining blocks.
REQ-031 Minimum core-side overhead: 2 cycles (IDLE, ISSUE) between cor_don and next cor_str.

Reset
REQ-032 rst low -> all outputs 0, FSM IDLE, pointer = channel 0, channel registers, counters, timer cleared, immediately, independent of clk.
REQ-033 rst asserted mid-job -> job lost, no fin/err after release; first cycle after release acts as idle.

Verification
REQ-034 Single job ch0, ini=5, nbk=3, core done 10 cycles after cor_str -> cor_cnt 5,6,7; blk_0 x3; fin_0 with third blk_0; bsy_0 low after.
REQ-035 Both req same cycle, nbk=2 each -> gnt_0,gnt_1 same cycle; cor_sel sequence 0,1,0,1.
REQ-036 ch1 ini=0xFFFFFFFF, nbk=2 -> cor_cnt 0xFFFFFFFF then 0x00000000.
REQ-037 TMO=16, core never responds -> err_0 16 cycles after WAIT entry, no fin_0, bsy_0=0, FSM serves ch1 next.
REQ-038 nbk=0 on ch0 -> gnt_0 then fin_0 next cycle, cor_str never asserted.
REQ-039 rst low during WAIT of ch0 job -> all outputs 0 at once; stray cor_don after release ignored; new req accepted normally.

Source files
------------

// File: rtl/chacha20_sched.sv
// chacha20_sched: two-channel job scheduler in front of one shared ChaCha20
// block core. Each channel accepts a job (key, nonce, initial block counter,
// block count), and the scheduler feeds the core one block at a time,
// alternating channels round-robin, with a per-block WAIT timeout.
//
// Ports
//   clk                 single clock, rising edge
//   rst                 asynchronous, active-low reset
//   req_x               per-channel job request (level)
//   key_x/non_x/ini_x   per-channel key, nonce, initial counter (valid with req_x)
//   nbk_x               per-channel number of blocks in the job
//   gnt_x               one-cycle pulse: job accepted
//   bsy_x               channel job in progress
//   blk_x               one-cycle pulse per completed keystream block
//   fin_x               one-cycle pulse: all blocks of the job done
//   err_x               one-cycle pulse: job aborted on core timeout
//   cor_key/non/cnt     operands to the shared core, stable ISSUE..WAIT
//   cor_str             one-cycle core start
//   cor_sel             channel currently in service
//   cor_don             one-cycle core completion pulse
module chacha20_sched #(
    parameter int unsigned TMO = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_0,
    input  logic         req_1,
    input  logic [255:0] key_0,
    input  logic [255:0] key_1,
    input  logic [95:0]  non_0,
    input  logic [95:0]  non_1,
    input  logic [31:0]  ini_0,
    input  logic [31:0]  ini_1,
    input  logic [7:0]   nbk_0,
    input  logic [7:0]   nbk_1,
    output logic         gnt_0,
    output logic         gnt_1,
    output logic         bsy_0,
    output logic         bsy_1,
    output logic         blk_0,
    output logic         blk_1,
    output logic         fin_0,
    output logic         fin_1,
    output logic         err_0,
    output logic         err_1,
    output logic [255:0] cor_key,
    output logic [95:0]  cor_non,
    output logic [31:0]  cor_cnt,
    output logic         cor_str,
    output logic         cor_sel,
    input  logic         cor_don
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    // Channel inputs gathered into arrays so both channels share one body.
    logic [1:0]   req;
    logic [255:0] key_in [2];
    logic [95:0]  non_in [2];
    logic [31:0]  ini_in [2];
    logic [7:0]   nbk_in [2];

    assign req       = {req_1, req_0};
    assign key_in[0] = key_0;
    assign key_in[1] = key_1;
    assign non_in[0] = non_0;
    assign non_in[1] = non_1;
    assign ini_in[0] = ini_0;
    assign ini_in[1] = ini_1;
    assign nbk_in[0] = nbk_0;
    assign nbk_in[1] = nbk_1;

    // Per-channel job state
    logic [255:0] key_q [2];
    logic [95:0]  non_q [2];
    logic [31:0]  cnt_q [2];
    logic [7:0]   rem_q [2];
    logic [1:0]   bsy_q, gnt_q, blk_q, fin_q, err_q;

    // Scheduler state
    state_t      state_q, state_d;
    logic        ptr_q, sel_q;
    logic [15:0] tmr_q;
    logic [1:0]  pend;
    logic        pick, load, don_hit, tmo_hit;

    assign pend = bsy_q & {rem_q[1] != 8'd0, rem_q[0] != 8'd0};

    always_comb begin
        state_d = state_q;
        pick    = ptr_q;
        load    = 1'b0;
        don_hit = 1'b0;
        tmo_hit = 1'b0;
        cor_str = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pend) begin
                    pick    = pend[ptr_q] ? ptr_q : ~ptr_q;
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cor_str = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes priority over a coincident timeout.
                if (cor_don) begin
                    don_hit = 1'b1;
                    state_d = S_IDLE;
                end else if (tmr_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
            tmr_q   <= '0;
            cor_key <= '0;
            cor_non <= '0;
            cor_cnt <= '0;
        end else begin
            state_q <= state_d;
            // Core operands are captured on the IDLE->ISSUE edge and then held
            // untouched until the next selection.
            if (load) begin
                sel_q   <= pick;
                cor_key <= key_q[pick];
                cor_non <= non_q[pick];
                cor_cnt <= cnt_q[pick];
            end
            if (state_q == S_ISSUE) begin
                ptr_q <= ~sel_q;
                tmr_q <= '0;
            end else if (state_q == S_WAIT) begin
                tmr_q <= tmr_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                key_q[i] <= '0;
                non_q[i] <= '0;
                cnt_q[i] <= '0;
                rem_q[i] <= '0;
            end
            bsy_q <= '0;
            gnt_q <= '0;
            blk_q <= '0;
            fin_q <= '0;
            err_q <= '0;
        end else begin
            gnt_q <= '0;
            blk_q <= '0;
            fin_q <= '0;
            err_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                if (!bsy_q[i]) begin
                    if (req[i]) begin
                        key_q[i] <= key_in[i];
                        non_q[i] <= non_in[i];
                        cnt_q[i] <= ini_in[i];
                        rem_q[i] <= nbk_in[i];
                        gnt_q[i] <= 1'b1;
                        bsy_q[i] <= 1'b1;
                    end
                end else if (rem_q[i] == 8'd0) begin
                    // Busy with nothing left only happens for a zero-block job:
                    // the normal last block clears bsy together with rem.
                    fin_q[i] <= 1'b1;
                    bsy_q[i] <= 1'b0;
                end else if (sel_q == 1'(i) && don_hit) begin
                    blk_q[i] <= 1'b1;
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                    rem_q[i] <= rem_q[i] - 8'd1;
                    if (rem_q[i] == 8'd1) begin
                        fin_q[i] <= 1'b1;
                        bsy_q[i] <= 1'b0;
                    end
                end else if (sel_q == 1'(i) && tmo_hit) begin
                    err_q[i] <= 1'b1;
                    bsy_q[i] <= 1'b0;
                    rem_q[i] <= '0;
                end
            end
        end
    end

    assign gnt_0   = gnt_q[0];
    assign gnt_1   = gnt_q[1];
    assign bsy_0   = bsy_q[0];
    assign bsy_1   = bsy_q[1];
    assign blk_0   = blk_q[0];
    assign blk_1   = blk_q[1];
    assign fin_0   = fin_q[0];
    assign fin_1   = fin_q[1];
    assign err_0   = err_q[0];
    assign err_1   = err_q[1];
    assign cor_sel = sel_q;

endmodule

// File: tb/tb_chacha20_sched.sv
// Directed testbench for chacha20_sched: round-robin interleave, counter
// wrap, zero-block jobs, WAIT timeout and asynchronous reset mid-job.
module tb_chacha20_sched;

  localparam logic [255:0] K0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K1 = 256'hffeeddccbbaa99887766554433221100ffeeddccbbaa99887766554433221100;
  localparam logic [255:0] K2 = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
  localparam logic [255:0] K3 = 256'hdeadbeefcafebabedeadbeefcafebabedeadbeefcafebabedeadbeefcafebabe;
  localparam logic [95:0]  N0 = 96'h000000090000004a00000000;
  localparam logic [95:0]  N1 = 96'h111111112222222233333333;
  localparam logic [95:0]  N2 = 96'ha5a5a5a55a5a5a5aa5a5a5a5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_0, req_1;
  logic [255:0] key_0, key_1;
  logic [95:0]  non_0, non_1;
  logic [31:0]  ini_0, ini_1;
  logic [7:0]   nbk_0, nbk_1;
  logic         gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1;
  logic         fin_0, fin_1, err_0, err_1;
  logic [255:0] cor_key;
  logic [95:0]  cor_non;
  logic [31:0]  cor_cnt;
  logic         cor_str, cor_sel, cor_don;

  int errors = 0;
  int checks = 0;

  chacha20_sched #(.TMO(16)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1),
    .key_0(key_0), .key_1(key_1),
    .non_0(non_0), .non_1(non_1),
    .ini_0(ini_0), .ini_1(ini_1),
    .nbk_0(nbk_0), .nbk_1(nbk_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1),
    .bsy_0(bsy_0), .bsy_1(bsy_1),
    .blk_0(blk_0), .blk_1(blk_1),
    .fin_0(fin_0), .fin_1(fin_1),
    .err_0(err_0), .err_1(err_1),
    .cor_key(cor_key), .cor_non(cor_non), .cor_cnt(cor_cnt),
    .cor_str(cor_str), .cor_sel(cor_sel), .cor_don(cor_don)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fail(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    errors++;
    $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic serve(input logic s, input logic [31:0] cnt,
                       input logic [255:0] k, input logic [95:0] nn,
                       input logic last, input int exp_n, input string tag);
    int n = 0;
    while (cor_str !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n !== exp_n) fail({tag, "_lat"}, n, exp_n);
    checks++; if (cor_sel !== s) fail({tag, "_sel"}, cor_sel, s);
    checks++; if (cor_cnt !== cnt) fail({tag, "_cnt"}, cor_cnt, cnt);
    checks++; if (cor_key !== k) fail({tag, "_key"}, cor_key, k);
    checks++; if (cor_non !== nn) fail({tag, "_non"}, cor_non, nn);
    repeat (9) tick();
    checks++; if (cor_str !== 1'b0) fail({tag, "_str_low"}, cor_str, 1'b0);
    checks++; if (cor_cnt !== cnt) fail({tag, "_cnt_hold"}, cor_cnt, cnt);
    tick();
    cor_don = 1'b1;
    tick();
    cor_don = 1'b0;
    checks++; if ((s ? blk_1 : blk_0) !== 1'b1) fail({tag, "_blk"}, (s ? blk_1 : blk_0), 1'b1);
    checks++; if ((s ? fin_1 : fin_0) !== last) fail({tag, "_fin"}, (s ? fin_1 : fin_0), last);
    checks++; if ((s ? bsy_1 : bsy_0) !== ~last) fail({tag, "_bsy"}, (s ? bsy_1 : bsy_0), ~last);
  endtask

  initial begin
    rst = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0;
    key_0 = '0; key_1 = '0; non_0 = '0; non_1 = '0;
    ini_0 = '0; ini_1 = '0; nbk_0 = '0; nbk_1 = '0;
    cor_don = 1'b0;
    #2;
    checks++;
    if ({gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
         err_0, err_1, cor_str, cor_sel} !== 12'h000)
      fail("rst_ctrl", {gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
                        err_0, err_1, cor_str, cor_sel}, 12'h000);
    checks++;
    if (|{cor_key, cor_non, cor_cnt} !== 1'b0)
      fail("rst_ops", |{cor_key, cor_non, cor_cnt}, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    key_0 = K0; non_0 = N0; ini_0 = 32'h0000_0100; nbk_0 = 8'd2;
    key_1 = K1; non_1 = N1; ini_1 = 32'hFFFF_FFFF; nbk_1 = 8'd2;
    req_0 = 1'b1; req_1 = 1'b1;
    tick();
    checks++;
    if ({gnt_0, gnt_1, bsy_0, bsy_1} !== 4'b1111)
      fail("dual_gnt", {gnt_0, gnt_1, bsy_0, bsy_1}, 4'b1111);
    req_0 = 1'b0; req_1 = 1'b0;
    serve(1'b0, 32'h0000_0100, K0, N0, 1'b0, 1, "dual_a0");
    serve(1'b1, 32'hFFFF_FFFF, K1, N1, 1'b0, 1, "dual_b1");
    serve(1'b0, 32'h0000_0101, K0, N0, 1'b1, 1, "dual_c0");
    serve(1'b1, 32'h0000_0000, K1, N1, 1'b1, 1, "dual_d1");
    tick();
    checks++;
    if ({bsy_0, bsy_1, blk_1, fin_1} !== 4'b0000)
      fail("dual_idle", {bsy_0, bsy_1, blk_1, fin_1}, 4'b0000);

    key_0 = K2; non_0 = N2; ini_0 = 32'd5; nbk_0 = 8'd3;
    req_0 = 1'b1;
    tick();
    checks++;
    if ({gnt_0, bsy_0} !== 2'b11) fail("one_gnt", {gnt_0, bsy_0}, 2'b11);
    ini_0 = 32'd99; nbk_0 = 8'd7;
    tick();
    checks++;
    if (gnt_0 !== 1'b0) fail("one_no_regnt", gnt_0, 1'b0);
    req_0 = 1'b0;
    serve(1'b0, 32'd5, K2, N2, 1'b0, 0, "one_b5");
    serve(1'b0, 32'd6, K2, N2, 1'b0, 1, "one_b6");
    serve(1'b0, 32'd7, K2, N2, 1'b1, 1, "one_b7");
    tick();
    checks++;
    if ({bsy_0, fin_0, blk_0, cor_str} !== 4'b0000)
      fail("one_after", {bsy_0, fin_0, blk_0, cor_str}, 4'b0000);

    nbk_0 = 8'd0;
    req_0 = 1'b1;
    tick();
    checks++;
    if ({gnt_0, bsy_0} !== 2'b11) fail("zero_gnt", {gnt_0, bsy_0}, 2'b11);
    req_0 = 1'b0;
    tick();
    checks++;
    if ({fin_0, bsy_0, cor_str} !== 3'b100) fail("zero_fin", {fin_0, bsy_0, cor_str}, 3'b100);
    tick();
    checks++;
    if ({fin_0, bsy_0, cor_str} !== 3'b000) fail("zero_after", {fin_0, bsy_0, cor_str}, 3'b000);
    tick();
    checks++;
    if (cor_str !== 1'b0) fail("zero_nostr", cor_str, 1'b0);

    ini_0 = 32'h20; nbk_0 = 8'd1;
    req_0 = 1'b1;
    tick();
    checks++;
    if (gnt_0 !== 1'b1) fail("tmo_gnt0", gnt_0, 1'b1);
    req_0 = 1'b0;
    key_1 = K3; ini_1 = 32'h40; nbk_1 = 8'd1;
    req_1 = 1'b1;
    tick();
    checks++;
    if ({cor_str, cor_sel, gnt_1} !== 3'b101)
      fail("tmo_issue", {cor_str, cor_sel, gnt_1}, 3'b101);
    req_1 = 1'b0;
    repeat (16) tick();
    checks++;
    if ({err_0, bsy_0} !== 2'b01) fail("tmo_pre", {err_0, bsy_0}, 2'b01);
    tick();
    checks++;
    if ({err_0, bsy_0, fin_0, blk_0} !== 4'b1000)
      fail("tmo_err", {err_0, bsy_0, fin_0, blk_0}, 4'b1000);
    serve(1'b1, 32'h40, K3, N1, 1'b1, 1, "tmo_ch1");

    ini_0 = 32'd9; nbk_0 = 8'd2;
    req_0 = 1'b1;
    tick();
    req_0 = 1'b0;
    tick();
    checks++;
    if (cor_str !== 1'b1) fail("mid_str", cor_str, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
         err_0, err_1, cor_str, cor_sel} !== 12'h000)
      fail("mid_rst_ctrl", {gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
                            err_0, err_1, cor_str, cor_sel}, 12'h000);
    checks++;
    if (|{cor_key, cor_non, cor_cnt} !== 1'b0)
      fail("mid_rst_ops", |{cor_key, cor_non, cor_cnt}, 1'b0);
    tick();
    rst = 1'b1;
    cor_don = 1'b1;
    tick();
    cor_don = 1'b0;
    checks++;
    if ({gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
         err_0, err_1, cor_str, cor_sel} !== 12'h000)
      fail("stray_don", {gnt_0, gnt_1, bsy_0, bsy_1, blk_0, blk_1, fin_0, fin_1,
                         err_0, err_1, cor_str, cor_sel}, 12'h000);
    tick();
    checks++;
    if ({cor_str, bsy_0, fin_0, err_0} !== 4'b0000)
      fail("stray_idle", {cor_str, bsy_0, fin_0, err_0}, 4'b0000);
    ini_1 = 32'd7; nbk_1 = 8'd1;
    req_1 = 1'b1;
    tick();
    checks++;
    if ({gnt_1, bsy_1} !== 2'b11) fail("post_gnt", {gnt_1, bsy_1}, 2'b11);
    req_1 = 1'b0;
    serve(1'b1, 32'd7, K3, N1, 1'b1, 1, "post_ch1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit");
  end

endmodule
